// File: rtl/sa_pkg.sv
// Shared constants for the 2x2 systolic-array feeder: widths, FSM encoding,
// and index helpers for the row-major packed matrix layout.
package sa_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;
  localparam int N      = 2;

  // Kept as plain constants so legacy netlists see a stable 3-bit encoding.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] FEED_LAST  = 2'd2;
  localparam logic [1:0] DRAIN_LAST = 2'd1;

  function automatic int unsigned el_idx(input int unsigned row, input int unsigned col);
    return row * N + col;
  endfunction

  function automatic int unsigned el_lo(input int unsigned row, input int unsigned col,
                                        input int unsigned dw);
    return el_idx(row, col) * dw;
  endfunction

endpackage

// File: rtl/sa_skew_mux.sv
// Registered operand streams for the array edge. Each register is loaded one
// cycle ahead so its value lines up with the FEED cycle it belongs to.
module sa_skew_mux #(
  parameter int DATA_W = sa_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            state,
  input  logic [1:0]            cnt,
  input  logic [4*DATA_W-1:0]   a_lat,
  input  logic [4*DATA_W-1:0]   b_lat,
  output logic [DATA_W-1:0]     a1,
  output logic [DATA_W-1:0]     a2,
  output logic [DATA_W-1:0]     b1,
  output logic [DATA_W-1:0]     b2
);
  import sa_pkg::*;

  logic signed [DATA_W-1:0] a00, a01, a10, a11;
  logic signed [DATA_W-1:0] b00, b01, b10, b11;
  logic signed [DATA_W-1:0] a1_nxt, a2_nxt, b1_nxt, b2_nxt;

  assign a00 = a_lat[el_lo(0, 0, DATA_W) +: DATA_W];
  assign a01 = a_lat[el_lo(0, 1, DATA_W) +: DATA_W];
  assign a10 = a_lat[el_lo(1, 0, DATA_W) +: DATA_W];
  assign a11 = a_lat[el_lo(1, 1, DATA_W) +: DATA_W];
  assign b00 = b_lat[el_lo(0, 0, DATA_W) +: DATA_W];
  assign b01 = b_lat[el_lo(0, 1, DATA_W) +: DATA_W];
  assign b10 = b_lat[el_lo(1, 0, DATA_W) +: DATA_W];
  assign b11 = b_lat[el_lo(1, 1, DATA_W) +: DATA_W];

  // CLEAR prepares k=0, FEED cnt=0 prepares k=1, FEED cnt=1 prepares k=2.
  always_comb begin
    a1_nxt = '0;
    a2_nxt = '0;
    b1_nxt = '0;
    b2_nxt = '0;
    if (state == S_CLEAR) begin
      a1_nxt = a00;
      b1_nxt = b00;
    end else if (state == S_FEED && cnt == 2'd0) begin
      a1_nxt = a01;
      a2_nxt = a10;
      b1_nxt = b10;
      b2_nxt = b01;
    end else if (state == S_FEED && cnt == 2'd1) begin
      a2_nxt = a11;
      b2_nxt = b11;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a1 <= '0;
      a2 <= '0;
      b1 <= '0;
      b2 <= '0;
    end else begin
      a1 <= a1_nxt;
      a2 <= a2_nxt;
      b1 <= b1_nxt;
      b2 <= b2_nxt;
    end
  end

endmodule

// File: rtl/sa_feeder.sv
// Host-side driver for the 2x2 systolic array: accepts A/B, clears the array,
// streams skewed operands, captures C once the last products land.
module sa_feeder #(
  parameter int DATA_W = sa_pkg::DATA_W,
  parameter int ACC_W  = sa_pkg::ACC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] a_mat,
  input  logic [4*DATA_W-1:0] b_mat,
  output logic                arr_clr,
  output logic [DATA_W-1:0]   a1,
  output logic [DATA_W-1:0]   a2,
  output logic [DATA_W-1:0]   b1,
  output logic [DATA_W-1:0]   b2,
  input  logic [ACC_W-1:0]    c11,
  input  logic [ACC_W-1:0]    c12,
  input  logic [ACC_W-1:0]    c21,
  input  logic [ACC_W-1:0]    c22,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    r11,
  output logic [ACC_W-1:0]    r12,
  output logic [ACC_W-1:0]    r21,
  output logic [ACC_W-1:0]    r22
);
  import sa_pkg::*;

  logic [2:0]          state;
  logic [1:0]          cnt;
  logic [4*DATA_W-1:0] a_lat;
  logic [4*DATA_W-1:0] b_lat;
  logic                accept;
  logic                capture;

  assign in_ready  = rst && (state == S_IDLE);
  assign out_valid = rst && (state == S_RESP);
  // The array also needs clearing while the feeder itself is held in reset.
  assign arr_clr   = !rst || (state == S_CLEAR);
  assign accept    = in_ready && in_valid;
  assign capture   = (state == S_DRAIN) && (cnt == DRAIN_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (in_valid) state <= S_CLEAR;
        S_CLEAR: begin
          state <= S_FEED;
          cnt   <= '0;
        end
        S_FEED: begin
          if (cnt == FEED_LAST) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) state <= S_RESP;
          else                   cnt   <= cnt + 2'd1;
        end
        S_RESP:  if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture: only on the accept edge, so later host changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_lat <= a_mat;
      b_lat <= b_mat;
    end
  end

  sa_skew_mux #(.DATA_W(DATA_W)) u_skew (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .cnt   (cnt),
    .a_lat (a_lat),
    .b_lat (b_lat),
    .a1    (a1),
    .a2    (a2),
    .b1    (b1),
    .b2    (b2)
  );

  // Result stage: c22 is final during the last DRAIN cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r11 <= '0;
      r12 <= '0;
      r21 <= '0;
      r22 <= '0;
    end else if (capture) begin
      r11 <= c11;
      r12 <= c12;
      r21 <= c21;
      r22 <= c22;
    end
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder with a behavioural 2x2 systolic array
// attached and results compared against a plain matrix product.
`timescale 1ns/1ps
module tb_sa_feeder;
  localparam int DW = 8;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   a_mat;
  logic [31:0]   b_mat;
  logic          arr_clr;
  logic [DW-1:0] a1, a2, b1, b2;
  logic [AW-1:0] c11, c12, c21, c22;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] r11, r12, r21, r22;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_feeder #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .arr_clr(arr_clr),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .out_valid(out_valid), .out_ready(out_ready),
    .r11(r11), .r12(r12), .r21(r21), .r22(r22)
  );

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rv(input logic [AW-1:0] v);
    return int'($signed(v));
  endfunction

  // Array plant: each PE forwards a/b with one cycle delay and accumulates a*b.
  int m11, m12, m21, m22;
  logic [DW-1:0] pa12, pb21, pa22, pb22;
  always @(posedge clk) begin
    if (arr_clr) begin
      m11 <= 0; m12 <= 0; m21 <= 0; m22 <= 0;
      pa12 <= '0; pb21 <= '0; pa22 <= '0; pb22 <= '0;
    end else begin
      m11  <= m11 + sx(a1) * sx(b1);
      m12  <= m12 + sx(pa12) * sx(b2);
      m21  <= m21 + sx(a2) * sx(pb21);
      m22  <= m22 + sx(pa22) * sx(pb22);
      pa12 <= a1;
      pb21 <= b1;
      pa22 <= a2;
      pb22 <= b2;
    end
  end
  assign c11 = m11[AW-1:0];
  assign c12 = m12[AW-1:0];
  assign c21 = m21[AW-1:0];
  assign c22 = m22[AW-1:0];

  function automatic int el(input logic [31:0] m, input int i, input int j);
    logic [7:0] v;
    v = m[(i*2+j)*8 +: 8];
    return sx(v);
  endfunction

  function automatic int prod(input logic [31:0] a, input logic [31:0] b, input int i, input int j);
    int s = 0;
    for (int k = 0; k < 2; k++) s += el(a, i, k) * el(b, k, j);
    return s;
  endfunction

  // Expected edge stream value at FEED step k (k outside 0..2 means not feeding).
  function automatic int exp_stream(input int which, input logic [31:0] a, input logic [31:0] b, input int k);
    case (which)
      0: return (k >= 0 && k < 2) ? el(a, 0, k) : 0;
      1: return (k >= 1 && k <= 2) ? el(a, 1, k-1) : 0;
      2: return (k >= 0 && k < 2) ? el(b, k, 0) : 0;
      default: return (k >= 1 && k <= 2) ? el(b, k-1, 1) : 0;
    endcase
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b, output int lat, output bit to);
    a_mat = a; b_mat = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_mat = $urandom; b_mat = $urandom;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !out_valid;
  endtask

  task automatic finish_resp();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_mat = '0; b_mat = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (arr_clr !== 1'b1) begin errors++; $display("FAIL reset_arr_clr got %b exp 1", arr_clr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if ({a1, a2, b1, b2} !== 32'h0) begin errors++; $display("FAIL reset_streams got %h exp 0", {a1, a2, b1, b2}); end
    checks++; if ({r11, r12, r21, r22} !== '0) begin errors++; $display("FAIL reset_r got %h exp 0", {r11, r12, r21, r22}); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
    checks++; if (arr_clr !== 1'b0) begin errors++; $display("FAIL idle_arr_clr got %b exp 0", arr_clr); end
  endtask

  task automatic test_basic();
    logic [31:0] a, b;
    logic [AW-1:0] rr [4];
    int s [4];
    a = 32'h04030201; b = 32'h08070605;
    checks++; if ({a1, a2, b1, b2} !== 32'h0 || arr_clr !== 1'b0) begin errors++; $display("FAIL basic_idle streams %h clr %b exp 0/0", {a1, a2, b1, b2}, arr_clr); end
    a_mat = a; b_mat = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a_mat = 32'hdeadbeef; b_mat = 32'h12345678;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      s[0] = sx(a1); s[1] = sx(a2); s[2] = sx(b1); s[3] = sx(b2);
      for (int w = 0; w < 4; w++) begin
        checks++;
        if (s[w] !== exp_stream(w, a, b, cyc - 2)) begin
          errors++; $display("FAIL basic_stream%0d cyc %0d got %0d exp %0d", w, cyc, s[w], exp_stream(w, a, b, cyc - 2));
        end
      end
      checks++; if (arr_clr !== (cyc == 1)) begin errors++; $display("FAIL basic_arr_clr cyc %0d got %b", cyc, arr_clr); end
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy cyc %0d ov %b ir %b exp 0/0", cyc, out_valid, in_ready); end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid at cycle 7 got %b exp 1", out_valid); end
    checks++; if ({a1, a2, b1, b2} !== 32'h0 || arr_clr !== 1'b0) begin errors++; $display("FAIL basic_resp streams %h clr %b exp 0/0", {a1, a2, b1, b2}, arr_clr); end
    rr = '{r11, r12, r21, r22};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rv(rr[i]) !== prod(a, b, i/2, i%2)) begin errors++; $display("FAIL basic_r%0d got %0d exp %0d", i, rv(rr[i]), prod(a, b, i/2, i%2)); end
    end
    checks++; if (rv(r11) !== 19 || rv(r22) !== 50) begin errors++; $display("FAIL basic_const r11 %0d r22 %0d exp 19/50", rv(r11), rv(r22)); end
    finish_resp();
  endtask

  task automatic test_extremes();
    logic [31:0] av [2];
    logic [31:0] bv [2];
    int expv [2];
    logic [AW-1:0] rr [4];
    int lat; bit to;
    av = '{32'h80808080, 32'h7f7f7f7f};
    bv = '{32'h80808080, 32'h80808080};
    expv = '{32768, -32512};
    for (int t = 0; t < 2; t++) begin
      launch(av[t], bv[t], lat, to);
      checks++; if (to) begin errors++; $display("FAIL extreme%0d_timeout got no out_valid exp 1", t); end
      rr = '{r11, r12, r21, r22};
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rv(rr[i]) !== expv[t]) begin errors++; $display("FAIL extreme%0d_r%0d got %0d exp %0d", t, i, rv(rr[i]), expv[t]); end
      end
      finish_resp();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [AW-1:0] rr [4];
    int lat; bit to;
    for (int j = 0; j < 8; j++) begin
      a = $urandom; b = $urandom;
      launch(a, b, lat, to);
      checks++; if (to || lat != 7) begin errors++; $display("FAIL random%0d_latency got %0d exp 7", j, lat); end
      rr = '{r11, r12, r21, r22};
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rv(rr[i]) !== prod(a, b, i/2, i%2)) begin errors++; $display("FAIL random%0d_r%0d got %0d exp %0d", j, i, rv(rr[i]), prod(a, b, i/2, i%2)); end
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      finish_resp();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, a2m, b2m;
    logic [AW-1:0] rr [4];
    int lat; bit to;
    a = $urandom; b = $urandom; a2m = $urandom; b2m = $urandom;
    launch(a, b, lat, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got no out_valid exp 1"); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold cyc %0d ov %b ir %b exp 1/0", c, out_valid, in_ready); end
      rr = '{r11, r12, r21, r22};
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rv(rr[i]) !== prod(a, b, i/2, i%2)) begin errors++; $display("FAIL bp_r%0d cyc %0d got %0d exp %0d", i, c, rv(rr[i]), prod(a, b, i/2, i%2)); end
      end
      in_valid = $urandom_range(0, 1); a_mat = $urandom; b_mat = $urandom;
      @(posedge clk); #1;
    end
    a_mat = a2m; b_mat = b2m; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || arr_clr !== 1'b0) begin errors++; $display("FAIL bp_idle ov %b ir %b clr %b exp 0/1/0", out_valid, in_ready, arr_clr); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (arr_clr !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept clr %b ir %b exp 1/0", arr_clr, in_ready); end
    lat = 1;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 7) begin errors++; $display("FAIL bp_job2_latency got %0d exp 7", lat); end
    rr = '{r11, r12, r21, r22};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rv(rr[i]) !== prod(a2m, b2m, i/2, i%2)) begin errors++; $display("FAIL bp_job2_r%0d got %0d exp %0d", i, rv(rr[i]), prod(a2m, b2m, i/2, i%2)); end
    end
    finish_resp();
  endtask

  task automatic test_mid_reset();
    logic [31:0] a, b, id;
    logic [AW-1:0] rr [4];
    int expv [4];
    int lat; bit to;
    a = 32'h7f7f7f7f; b = 32'h7f7f7f7f; id = 32'h01000001;
    a_mat = a; b_mat = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sx(a1) !== el(a, 0, 1)) begin errors++; $display("FAIL mr_feed_k1 a1 got %0d exp %0d", sx(a1), el(a, 0, 1)); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (arr_clr !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mr_ctrl clr %b ir %b ov %b exp 1/0/0", arr_clr, in_ready, out_valid); end
    checks++; if ({a1, a2, b1, b2} !== 32'h0) begin errors++; $display("FAIL mr_streams got %h exp 0", {a1, a2, b1, b2}); end
    checks++; if ({r11, r12, r21, r22} !== '0) begin errors++; $display("FAIL mr_r got %h exp 0", {r11, r12, r21, r22}); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_idle in_ready got %b exp 1", in_ready); end
    launch(id, id, lat, to);
    checks++; if (to || lat != 7) begin errors++; $display("FAIL mr_ident_latency got %0d exp 7", lat); end
    expv = '{1, 0, 0, 1};
    rr = '{r11, r12, r21, r22};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rv(rr[i]) !== expv[i]) begin errors++; $display("FAIL mr_ident_r%0d got %0d exp %0d", i, rv(rr[i]), expv[i]); end
    end
    finish_resp();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ja [3];
    logic [31:0] jb [3];
    int acc_t [3];
    logic [AW-1:0] rr [4];
    int cyc, acc, got;
    for (int j = 0; j < 3; j++) begin ja[j] = $urandom; jb[j] = $urandom; end
    cyc = 0; acc = 0; got = 0;
    a_mat = ja[0]; b_mat = jb[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      if (in_ready && acc < 3) begin acc_t[acc] = cyc; acc++; end
      if (out_valid) begin
        rr = '{r11, r12, r21, r22};
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (rv(rr[i]) !== prod(ja[got], jb[got], i/2, i%2)) begin
            errors++; $display("FAIL b2b_job%0d_r%0d got %0d exp %0d", got, i, rv(rr[i]), prod(ja[got], jb[got], i/2, i%2));
          end
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc < 3) begin a_mat = ja[acc]; b_mat = jb[acc]; end
      else begin in_valid = 1'b0; a_mat = $urandom; b_mat = $urandom; end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (got != 3 || acc != 3) begin errors++; $display("FAIL b2b_count got %0d results %0d accepts exp 3/3", got, acc); end
    if (acc == 3) begin
      for (int j = 1; j < 3; j++) begin
        checks++;
        if (acc_t[j] - acc_t[j-1] != 8) begin errors++; $display("FAIL b2b_period%0d got %0d exp 8", j, acc_t[j] - acc_t[j-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_random();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_feeder.md
# sa_feeder

Host-side driver for the 2x2 systolic matrix-multiply array. It accepts one pair of 2x2 signed int8 matrices A and B over a valid/ready handshake and clears the array's accumulators. It then streams the operands into the array's a1/a2/b1/b2 edge with the diagonal skew the array expects. Finally it samples c11..c22 once all partial products have landed and returns the product C = A·B to the host over a second valid/ready handshake.

## Interface
Parameters:
- DATA_W, 8: operand width, signed.
- ACC_W, 18: accumulator/result width, signed; must match the array.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  **synchronous, active-low** reset.
- in_valid  in  1  host offers a job.
- in_ready  out  1  feeder can accept a job.
- a_mat  in  4*DATA_W  A packed row-major: A00 [7:0], A01 [15:8], A10 [23:16], A11 [31:24].
- b_mat  in  4*DATA_W  B, same packing.
- arr_clr  out  1  active-high clear to the array's accumulators and pipeline registers.
- a1, a2  out  DATA_W  row operand streams into the array (row 1, row 2).
- b1, b2  out  DATA_W  column operand streams into the array (column 1, column 2).
- c11, c12, c21, c22  in  ACC_W  array accumulator outputs.
- out_valid  out  1  result held on r11..r22.
- out_ready  in  1  host accepts the result.
- r11, r12, r21, r22  out  ACC_W  captured C elements.

## Operation
- Array contract:
  - Each PE registers a_in→a_out and b_in→b_out with 1-cycle delay.
  - Each PE accumulates c <= c + a_in*b_in every edge.
  - arr_clr zeroes c and the pass-through registers.
- FSM states and transitions:
  - IDLE → CLEAR on in_valid && in_ready. a_mat and b_mat are latched on that edge.
  - CLEAR lasts 1 cycle. arr_clr=1.
  - FEED lasts 3 cycles (k=0..2). The 2-bit counter cnt is reused here and in DRAIN.
  - DRAIN lasts 2 cycles, with all streams zero. On the last DRAIN edge, c11..c22 are registered into r11..r22.
  - RESP holds out_valid=1 until out_valid && out_ready, then → IDLE.
- in_ready = 1 only in IDLE. There is one job in flight; no input buffering.
- Skew schedule, FEED k=0/1/2:
  - a1 = A00, A01, 0
  - a2 = 0, A10, A11
  - b1 = B00, B10, 0
  - b2 = 0, B01, B11
- Streams are 0 in every state except FEED.
- Streams come from flops or from latched registers selected by state/cnt. There is no combinational path from a_mat/b_mat to a1..b2.
- Arithmetic: each c is a sum of 2 int8×int8 products. The range is [-32512, 32768], which fits ACC_W=18. The feeder adds no width logic; r = c bit-exact.
- r11..r22 are stable for the whole RESP state. a_mat/b_mat changes after acceptance have no effect.

## Timing
- Reset values: in_ready=0 while rst=0, then 1 in IDLE. arr_clr=1 during reset. out_valid=0. a1..b2=0. r11..r22=0.
- Reset at any point, including mid-FEED or in RESP, returns to IDLE and discards the job. arr_clr stays asserted for the reset cycles.
- Counting the accept edge as cycle 0: CLEAR is cycle 1, FEED is cycles 2-4, DRAIN is cycles 5-6, and out_valid=1 from cycle 7.
  - Minimum accept-to-result latency is 7 cycles.
  - Minimum job-to-job period is 8 cycles (out handshake in cycle 7, IDLE in cycle 8).
- c22 is final in cycle 6: its last operands arrive in FEED k=2+1 via the array pipeline. The capture edge is the end of cycle 6.
- Simultaneous out handshake and in_valid: the new job is not accepted until the IDLE cycle that follows.
- in_valid asserted in non-IDLE states is ignored and causes no side effects.

## Structure
- Package sa_pkg holds:
  - DATA_W, ACC_W, N=2.
  - The state enum {IDLE, CLEAR, FEED, DRAIN, RESP}.
  - Matrix element index helpers for the packed layout.
- One sub-module, sa_skew_mux: given the latched A/B, state and cnt, it produces the registered a1/a2/b1/b2. The top module holds the FSM, handshakes and result registers.
- The integration top connects sa_feeder to systolic_array. arr_clr maps onto the array's rst input, with polarity adapted at integration.

## Test plan
- Basic product: A=[[1,2],[3,4]], B=[[5,6],[7,8]] → r11=19, r12=22, r21=43, r22=50. out_valid must rise exactly 7 cycles after acceptance.
- Extremes: all A and B elements = -128 → all r = 32768. Then A all 127, B all -128 → all r = -32512.
- Stream check: A=[[1,2],[3,4]], B=[[5,6],[7,8]] → FEED cycles show a1 1,2,0; a2 0,3,4; b1 5,7,0; b2 0,6,8. All streams are 0 outside FEED, and arr_clr is high only in CLEAR and reset.
- Backpressure: hold out_ready=0 for 5 cycles in RESP → r stable and in_ready=0 throughout. in_valid pulses are ignored. The next job is accepted only after the out handshake plus 1 cycle.
- Reset mid-operation: assert rst=0 during FEED k=1 → next cycle all outputs are at reset values and arr_clr=1. A following job with A=B=identity returns r=[[1,0],[0,1]].
- Back-to-back: three jobs with in_valid and out_ready held high → each result is correct, and accepts occur 8 cycles apart.
